// File: rtl/poly_op_ctrl_if.sv
// Request/status bundle between an operation requester and poly_op_ctrl.
// The controller side also feeds mode/clk_counter to the address generator.
interface poly_op_ctrl_if;
  logic       start;
  logic [1:0] op;
  logic       busy;
  logic       done;
  logic [1:0] mode;
  logic [7:0] clk_counter;
  logic [2:0] layer;
  logic       rd_en;
  logic       wr_en;

  modport master (
    output start, op,
    input  busy, done, mode, clk_counter, layer, rd_en, wr_en
  );

  modport slave (
    input  start, op,
    output busy, done, mode, clk_counter, layer, rd_en, wr_en
  );
endinterface

// File: rtl/poly_op_ctrl.sv
// Sequencing controller for the NTT/polynomial address generator: walks
// clk_counter through each operation's schedule and emits aligned rd/wr strobes.
module poly_op_ctrl #(
  parameter int PIPE_LAT = 10
) (
  input  logic          clk,
  input  logic          rst,
  poly_op_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]    OP_MULT    = 2'd2;
  localparam int            DW         = $clog2(PIPE_LAT);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [1:0]           mode_r;
  logic [7:0]           cnt_r;
  logic [DW-1:0]        drain_r;
  logic [PIPE_LAT-1:0]  dly_r;
  logic                 is_ntt_s;
  logic                 busy_s;
  logic                 done_s;
  logic                 rd_en_s;
  logic                 wr_en_s;
  logic [2:0]           layer_s;

  // NTT and INVNTT share the layered schedule; both have op[1]=0.
  assign is_ntt_s = ~mode_r[1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_nxt_s = ST_RUN;
        else           state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (is_ntt_s) begin
          if (cnt_r[4:0] == 5'd31) state_nxt_s = ST_DRAIN;
          else                     state_nxt_s = ST_RUN;
        end else if (mode_r == OP_MULT) begin
          if (cnt_r == 8'd145) state_nxt_s = ST_DONE;
          else                 state_nxt_s = ST_RUN;
        end else begin
          if (cnt_r == 8'd69) state_nxt_s = ST_DONE;
          else                state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_r != DRAIN_LAST)    state_nxt_s = ST_DRAIN;
        else if (cnt_r[7:5] == 3'd6)  state_nxt_s = ST_DONE;
        else                          state_nxt_s = ST_RUN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Schedule counter, latched mode, drain timer and read-to-write delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r  <= 2'd0;
      cnt_r   <= 8'd0;
      drain_r <= '0;
      dly_r   <= '0;
    end else begin
      dly_r <= {dly_r[PIPE_LAT-2:0], rd_en_s};
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            mode_r  <= bus.op;
            cnt_r   <= 8'd0;
            drain_r <= '0;
            dly_r   <= '0;
          end else begin
            mode_r <= mode_r;
          end
        end
        ST_RUN: begin
          drain_r <= '0;
          if (state_nxt_s == ST_RUN) cnt_r <= cnt_r + 8'd1;
          else                       cnt_r <= cnt_r;
        end
        ST_DRAIN: begin
          drain_r <= drain_r + {{(DW-1){1'b0}}, 1'b1};
          // Leaving DRAIN back to RUN steps onto the next layer's base.
          if (state_nxt_s == ST_RUN) cnt_r <= cnt_r + 8'd1;
          else                       cnt_r <= cnt_r;
        end
        ST_DONE: cnt_r <= cnt_r;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Output decode from registered state and counter.
  always_comb begin
    busy_s  = 1'b0;
    done_s  = 1'b0;
    rd_en_s = 1'b0;
    wr_en_s = 1'b0;
    layer_s = 3'd0;
    if (is_ntt_s) layer_s = cnt_r[7:5];
    else          layer_s = 3'd0;
    case (state_r)
      ST_IDLE: busy_s = 1'b0;
      ST_RUN: begin
        busy_s = 1'b1;
        if (is_ntt_s) begin
          rd_en_s = 1'b1;
          wr_en_s = dly_r[PIPE_LAT-1];
        end else if (mode_r == OP_MULT) begin
          rd_en_s = (cnt_r <= 8'd127);
          wr_en_s = (cnt_r >= 8'd18) && (cnt_r <= 8'd145) && (cnt_r[1:0] == 2'b01);
        end else begin
          rd_en_s = (cnt_r <= 8'd63);
          wr_en_s = (cnt_r >= 8'd6) && cnt_r[0];
        end
      end
      ST_DRAIN: begin
        busy_s  = 1'b1;
        wr_en_s = dly_r[PIPE_LAT-1];
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
  end

  assign bus.busy        = busy_s;
  assign bus.done        = done_s;
  assign bus.mode        = mode_r;
  assign bus.clk_counter = cnt_r;
  assign bus.layer       = layer_s;
  assign bus.rd_en       = rd_en_s;
  assign bus.wr_en       = wr_en_s;

endmodule

// File: tb/tb_poly_op_ctrl.sv
// Bench for poly_op_ctrl: per-cycle comparison against a schedule model
// built from the operation rules, plus table, random and reset-abort runs.
module tb_poly_op_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  poly_op_ctrl_if bus();

  poly_op_ctrl #(.PIPE_LAT(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] mode;
    logic [7:0] cnt;
    logic [2:0] layer;
    logic       rd;
    logic       wr;
  } obs_t;

  typedef struct {
    logic [1:0] op;
    bit         noise;
    int         rd_n;
    int         wr_n;
    int         done_e;
  } vec_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic obs_t sample();
    obs_t o;
    o.busy  = bus.busy;
    o.done  = bus.done;
    o.mode  = bus.mode;
    o.cnt   = bus.clk_counter;
    o.layer = bus.layer;
    o.rd    = bus.rd_en;
    o.wr    = bus.wr_en;
    return o;
  endfunction

  task automatic check_obs(input string name, input int idx, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got busy=%0b done=%0b mode=%0d cnt=%0d layer=%0d rd=%0b wr=%0b, want busy=%0b done=%0b mode=%0d cnt=%0d layer=%0d rd=%0b wr=%0b",
               name, idx, got.busy, got.done, got.mode, got.cnt, got.layer, got.rd, got.wr,
               exp.busy, exp.done, exp.mode, exp.cnt, exp.layer, exp.rd, exp.wr);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // Expected trace, one entry per cycle after the start edge, ending with DONE.
  task automatic build_model(input logic [1:0] op);
    obs_t e;
    int   n;
    int   rd_max;
    exp_q.delete();
    e = '0;
    e.busy = 1'b1;
    e.mode = op;
    if (op < 2'd2) begin
      for (int l = 0; l < 7; l++) begin
        for (int k = 0; k < 32; k++) begin
          e.cnt = 8'(32 * l + k); e.rd = 1'b1; exp_q.push_back(e);
        end
        for (int d = 0; d < 10; d++) begin
          e.cnt = 8'(32 * l + 31); e.rd = 1'b0; exp_q.push_back(e);
        end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        e.wr = (i >= 10) ? exp_q[i - 10].rd : 1'b0;
        e.layer = e.cnt[7:5];
        exp_q[i] = e;
      end
    end else begin
      n      = (op == 2'd2) ? 146 : 70;
      rd_max = (op == 2'd2) ? 127 : 63;
      for (int c = 0; c < n; c++) begin
        e.cnt = 8'(c);
        e.rd  = (c <= rd_max);
        if (op == 2'd2) e.wr = (c >= 18) && (c % 4 == 1);
        else            e.wr = (c >= 6) && (c % 2 == 1);
        exp_q.push_back(e);
      end
    end
    e = exp_q[exp_q.size() - 1];
    e.done = 1'b1; e.rd = 1'b0; e.wr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input logic [1:0] op, input bit noise, input int stop_at,
                        output int rd_n, output int wr_n, output int done_n, output int done_idx);
    obs_t got;
    obs_t e;
    rd_n = 0; wr_n = 0; done_n = 0; done_idx = -1;
    build_model(op);
    bus.op    = op;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (stop_at >= 0 && i == stop_at) return;
      got = sample();
      check_obs("trace", i, got, exp_q[i]);
      rd_n += int'(got.rd);
      wr_n += int'(got.wr);
      if (got.done) begin
        done_n++;
        if (done_idx < 0) done_idx = i;
      end
      if (noise) begin
        bus.start = 1'($urandom());
        bus.op    = 2'($urandom());
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.op    = 2'd0;
    e = exp_q[exp_q.size() - 1];
    e.busy = 1'b0; e.done = 1'b0;
    check_obs("idle_after", 0, sample(), e);
  endtask

  vec_t vt[6];

  initial begin
    int   rd_n, wr_n, done_n, done_idx;
    obs_t zero;
    logic [1:0] rop;
    zero      = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;

    vt[0] = '{op: 2'd0, noise: 1'b0, rd_n: 224, wr_n: 224, done_e: 294};
    vt[1] = '{op: 2'd1, noise: 1'b0, rd_n: 224, wr_n: 224, done_e: 294};
    vt[2] = '{op: 2'd2, noise: 1'b0, rd_n: 128, wr_n: 32,  done_e: 146};
    vt[3] = '{op: 2'd3, noise: 1'b0, rd_n: 64,  wr_n: 32,  done_e: 70};
    vt[4] = '{op: 2'd1, noise: 1'b1, rd_n: 224, wr_n: 224, done_e: 294};
    vt[5] = '{op: 2'd3, noise: 1'b1, rd_n: 64,  wr_n: 32,  done_e: 70};

    repeat (3) @(posedge clk);
    #1;
    check_obs("in_reset", 0, sample(), zero);
    rst = 1'b0;
    @(posedge clk); #1;
    check_obs("after_reset", 0, sample(), zero);

    for (int t = 0; t < 6; t++) begin
      run_op(vt[t].op, vt[t].noise, -1, rd_n, wr_n, done_n, done_idx);
      check_int($sformatf("rd_count_v%0d", t), rd_n, vt[t].rd_n);
      check_int($sformatf("wr_count_v%0d", t), wr_n, vt[t].wr_n);
      check_int($sformatf("done_count_v%0d", t), done_n, 1);
      check_int($sformatf("done_edge_v%0d", t), done_idx, vt[t].done_e);
    end

    for (int r = 0; r < 6; r++) begin
      rop = 2'($urandom_range(0, 3));
      run_op(rop, 1'b1, -1, rd_n, wr_n, done_n, done_idx);
      check_int($sformatf("rnd_rd_count_%0d", r), rd_n, vt[rop].rd_n);
      check_int($sformatf("rnd_wr_count_%0d", r), wr_n, vt[rop].wr_n);
      check_int($sformatf("rnd_done_count_%0d", r), done_n, 1);
      check_int($sformatf("rnd_done_edge_%0d", r), done_idx, vt[rop].done_e);
    end

    // Abort an NTT in layer 3 DRAIN, then a MULT must run cleanly from zero.
    run_op(2'd0, 1'b0, 161, rd_n, wr_n, done_n, done_idx);
    check_int("pre_abort_done", done_n, 0);
    #2;
    rst = 1'b1;
    #1;
    check_obs("abort_async", 0, sample(), zero);
    @(posedge clk); #1;
    check_obs("abort_held", 0, sample(), zero);
    rst = 1'b0;
    @(posedge clk); #1;
    check_obs("abort_release", 0, sample(), zero);
    run_op(2'd2, 1'b0, -1, rd_n, wr_n, done_n, done_idx);
    check_int("post_abort_rd", rd_n, 128);
    check_int("post_abort_wr", wr_n, 32);
    check_int("post_abort_done_edge", done_idx, 146);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
